// File: rtl/data_mem_pkg.sv
// Shared types for the banked data memory.
// Sequencer states and the lane-count helper.
package data_mem_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } mem_state_t;

  function automatic int BYTES(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Storage core: combinational read port,
// lane-masked synchronous write port.
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic                  Clk,
  input  logic                  we,
  input  logic [BYTES(W)-1:0]   be,
  input  logic [A-1:0]          addr,
  input  logic [W-1:0]          wdata,
  output logic [W-1:0]          rdata
);

  localparam int NB = BYTES(W);

  logic [W-1:0] core [2**A];

  always_ff @(posedge Clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) core[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = core[addr];

endmodule

// File: rtl/data_mem_banked.sv
// Single-port data memory with byte lanes,
// post-reset clear sequencer and req/ready handshake.
module data_mem_banked
  import data_mem_pkg::*;
#(
  parameter int W              = 8,
  parameter int A              = 8,
  parameter int RD_LAT         = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Req,
  input  logic                WriteEn,
  input  logic [BYTES(W)-1:0] ByteEn,
  input  logic [A-1:0]        DataAddress,
  input  logic [W-1:0]        DataIn,
  output logic                Ready,
  output logic                Busy,
  output logic [W-1:0]        DataOut,
  output logic                DataValid
);

  localparam int NB = BYTES(W);

  mem_state_t      state;
  logic [A-1:0]    cnt;
  logic            clearing;
  logic            acc;
  logic            rd_acc;
  logic            arr_we;
  logic [NB-1:0]   arr_be;
  logic [A-1:0]    arr_addr;
  logic [W-1:0]    arr_wdata;
  logic [W-1:0]    rdata;

  assign clearing = ~Reset & (state == ST_CLEAR);
  assign Ready    = ~Reset & (state == ST_RUN);
  assign Busy     = Reset ? (CLEAR_ON_RESET != 0)
                          : (state == ST_CLEAR);
  assign acc      = Req & Ready;
  assign rd_acc   = acc & ~WriteEn;

  // The clear sequencer owns the write port while active.
  always_comb begin
    arr_we    = acc & WriteEn;
    arr_be    = ByteEn;
    arr_addr  = DataAddress;
    arr_wdata = DataIn;
    if (clearing) begin
      arr_we    = 1'b1;
      arr_be    = '1;
      arr_addr  = cnt;
      arr_wdata = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt   <= '0;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) state <= ST_RUN;
    end
  end

  data_mem_array #(
    .W (W),
    .A (A)
  ) u_array (
    .Clk   (Clk),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (rdata)
  );

  generate
    if (RD_LAT == 0) begin : g_comb
      assign DataOut   = rdata;
      assign DataValid = rd_acc;
    end else begin : g_reg
      logic [W-1:0] dout_q;
      logic         dv_q;

      always_ff @(posedge Clk) begin
        if (Reset) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else if (rd_acc) begin
          dout_q <= rdata;
          dv_q   <= 1'b1;
        end else begin
          dv_q   <= 1'b0;
        end
      end

      assign DataOut   = dout_q;
      assign DataValid = dv_q;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_banked.sv
// Bench for data_mem_banked: comb-read, registered-read
// and no-clear instances against an array model.
module tb_data_mem_banked;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        WriteEn = 1'b0;
  logic [1:0]  ByteEn = 2'b00;
  logic [3:0]  DataAddress = 4'd0;
  logic [15:0] DataIn = 16'h0;

  logic        rdy0, bsy0, dv0;
  logic [15:0] do0;
  logic        rdy1, bsy1, dv1;
  logic [15:0] do1;
  logic        rdy2, bsy2, dv2;
  logic [15:0] do2;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [16];
  bit          m_ready = 1'b0;
  int          clear_left = 16;
  logic [15:0] e_do1 = 16'h0;
  logic        e_dv1 = 1'b0;

  always #5 Clk = ~Clk;

  data_mem_banked #(
    .W(16), .A(4), .RD_LAT(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .WriteEn(WriteEn),
    .ByteEn(ByteEn), .DataAddress(DataAddress), .DataIn(DataIn),
    .Ready(rdy0), .Busy(bsy0), .DataOut(do0), .DataValid(dv0)
  );

  data_mem_banked #(
    .W(16), .A(4), .RD_LAT(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .WriteEn(WriteEn),
    .ByteEn(ByteEn), .DataAddress(DataAddress), .DataIn(DataIn),
    .Ready(rdy1), .Busy(bsy1), .DataOut(do1), .DataValid(dv1)
  );

  data_mem_banked #(
    .W(16), .A(4), .RD_LAT(1), .CLEAR_ON_RESET(0)
  ) dut2 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .WriteEn(WriteEn),
    .ByteEn(ByteEn), .DataAddress(DataAddress), .DataIn(DataIn),
    .Ready(rdy2), .Busy(bsy2), .DataOut(do2), .DataValid(dv2)
  );

  task automatic drive(input logic rst, input logic req,
                       input logic we, input logic [1:0] be,
                       input logic [3:0] a, input logic [15:0] d);
    @(negedge Clk);
    Reset = rst;
    Req = req;
    WriteEn = we;
    ByteEn = be;
    DataAddress = a;
    DataIn = d;
    #1;
  endtask

  // Model: memory is unavailable for 16 cycles after reset,
  // then reads as zero; accepted writes update enabled bytes.
  task automatic tick;
    bit acc;
    @(posedge Clk);
    acc = Req && m_ready && !Reset;
    if (Reset) begin
      clear_left = 16;
      m_ready = 1'b0;
      e_do1 = 16'h0;
      e_dv1 = 1'b0;
    end else begin
      if (acc && !WriteEn) begin
        e_do1 = mem[DataAddress];
        e_dv1 = 1'b1;
      end else begin
        e_dv1 = 1'b0;
      end
      if (acc && WriteEn) begin
        if (ByteEn[0]) mem[DataAddress][7:0] = DataIn[7:0];
        if (ByteEn[1]) mem[DataAddress][15:8] = DataIn[15:8];
      end
      if (!m_ready) begin
        clear_left--;
        if (clear_left == 0) begin
          for (int i = 0; i < 16; i++) mem[i] = 16'h0;
          m_ready = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 1, 2'b11, 4'd5, 16'hBEEF);
      n_cmp++;
      if (rdy0 !== 1'b0 || bsy0 !== 1'b1 ||
          rdy2 !== 1'b0 || bsy2 !== 1'b0) begin
        n_err++;
        $display("FAIL reset_flags got rdy0=%b bsy0=%b rdy2=%b bsy2=%b want 0 1 0 0",
                 rdy0, bsy0, rdy2, bsy2);
      end
      tick;
      n_cmp++;
      if (do1 !== 16'h0 || dv1 !== 1'b0 ||
          do2 !== 16'h0 || dv2 !== 1'b0) begin
        n_err++;
        $display("FAIL reset_regs got do1=%h dv1=%b do2=%h dv2=%b want 0",
                 do1, dv1, do2, dv2);
      end
    end
  endtask

  task automatic test_clear;
    int busy_n = 0;
    while (!m_ready && busy_n < 40) begin
      drive(0, 1, ~busy_n[0], 2'b11, 4'd9, 16'hFFFF);
      n_cmp++;
      if (bsy0 !== 1'b1 || rdy0 !== 1'b0 || dv0 !== 1'b0) begin
        n_err++;
        $display("FAIL clear_busy cyc=%0d got bsy=%b rdy=%b dv=%b want 1 0 0",
                 busy_n, bsy0, rdy0, dv0);
      end
      if (busy_n == 0) begin
        n_cmp++;
        if (rdy2 !== 1'b1 || bsy2 !== 1'b0) begin
          n_err++;
          $display("FAIL noclear_ready got rdy=%b bsy=%b want 1 0",
                   rdy2, bsy2);
        end
      end
      tick;
      n_cmp++;
      if (dv1 !== 1'b0) begin
        n_err++;
        $display("FAIL clear_dv1 got %b want 0", dv1);
      end
      busy_n++;
    end
    for (int a = 0; a < 16; a++) begin
      drive(0, 1, 0, 2'b00, 4'(a), 16'h0);
      n_cmp++;
      if (rdy0 !== 1'b1 || bsy0 !== 1'b0 ||
          do0 !== 16'h0 || dv0 !== 1'b1) begin
        n_err++;
        $display("FAIL clear_read a=%0d got rdy=%b bsy=%b do=%h dv=%b want 1 0 0000 1",
                 a, rdy0, bsy0, do0, dv0);
      end
      tick;
      n_cmp++;
      if (do1 !== 16'h0 || dv1 !== 1'b1) begin
        n_err++;
        $display("FAIL clear_read1 a=%0d got do=%h dv=%b want 0000 1",
                 a, do1, dv1);
      end
    end
  endtask

  task automatic test_byte_lane;
    drive(0, 1, 1, 2'b11, 4'd3, 16'hABCD);
    tick;
    drive(0, 1, 1, 2'b10, 4'd3, 16'h1200);
    tick;
    drive(0, 1, 0, 2'b00, 4'd3, 16'h0);
    n_cmp++;
    if (do0 !== 16'h12CD || dv0 !== 1'b1) begin
      n_err++;
      $display("FAIL byte_lane got do=%h dv=%b want 12cd 1", do0, dv0);
    end
    tick;
    n_cmp++;
    if (do1 !== 16'h12CD || dv1 !== 1'b1) begin
      n_err++;
      $display("FAIL byte_lane1 got do=%h dv=%b want 12cd 1", do1, dv1);
    end
  endtask

  task automatic test_reg_read;
    drive(0, 1, 1, 2'b11, 4'd7, 16'h5A5A);
    tick;
    n_cmp++;
    if (dv1 !== 1'b0) begin
      n_err++;
      $display("FAIL rr_write_dv got %b want 0", dv1);
    end
    drive(0, 1, 0, 2'b00, 4'd7, 16'h0);
    tick;
    n_cmp++;
    if (do1 !== 16'h5A5A || dv1 !== 1'b1) begin
      n_err++;
      $display("FAIL rr_data got do=%h dv=%b want 5a5a 1", do1, dv1);
    end
    drive(0, 0, 0, 2'b00, 4'd2, 16'h0);
    tick;
    n_cmp++;
    if (do1 !== 16'h5A5A || dv1 !== 1'b0) begin
      n_err++;
      $display("FAIL rr_hold got do=%h dv=%b want 5a5a 0", do1, dv1);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] a = 4'd15;
    drive(0, 1, 1, 2'b11, a, 16'h0011);
    tick;
    a = a + 4'd1;
    drive(0, 1, 1, 2'b11, a, 16'h0022);
    tick;
    drive(0, 0, 0, 2'b00, 4'd15, 16'h0);
    n_cmp++;
    if (do0 !== 16'h0011 || dv0 !== 1'b0) begin
      n_err++;
      $display("FAIL wrap15_idle got do=%h dv=%b want 0011 0", do0, dv0);
    end
    drive(0, 1, 0, 2'b00, 4'd15, 16'h0);
    n_cmp++;
    if (do0 !== 16'h0011 || dv0 !== 1'b1) begin
      n_err++;
      $display("FAIL wrap15_req got do=%h dv=%b want 0011 1", do0, dv0);
    end
    tick;
    drive(0, 0, 0, 2'b00, 4'd0, 16'h0);
    n_cmp++;
    if (do0 !== 16'h0022 || dv0 !== 1'b0) begin
      n_err++;
      $display("FAIL wrap0_idle got do=%h dv=%b want 0022 0", do0, dv0);
    end
    drive(0, 1, 0, 2'b00, 4'd0, 16'h0);
    n_cmp++;
    if (do0 !== 16'h0022 || dv0 !== 1'b1) begin
      n_err++;
      $display("FAIL wrap0_req got do=%h dv=%b want 0022 1", do0, dv0);
    end
    tick;
  endtask

  task automatic test_random;
    logic        req, we;
    logic [1:0]  be;
    logic [3:0]  a;
    logic [15:0] d;
    for (int i = 0; i < 300; i++) begin
      req = 1'($urandom_range(0, 3) != 0);
      we  = 1'($urandom_range(0, 1));
      be  = 2'($urandom_range(0, 3));
      a   = 4'($urandom_range(0, 15));
      d   = 16'($urandom);
      drive(0, req, we, be, a, d);
      n_cmp++;
      if (do0 !== mem[a] || dv0 !== (req & ~we)) begin
        n_err++;
        $display("FAIL rand_comb i=%0d a=%0d got do=%h dv=%b want %h %b",
                 i, a, do0, dv0, mem[a], req & ~we);
      end
      tick;
      n_cmp++;
      if (dv1 !== e_dv1 || do1 !== e_do1) begin
        n_err++;
        $display("FAIL rand_reg i=%0d got do=%h dv=%b want %h %b",
                 i, do1, dv1, e_do1, e_dv1);
      end
    end
  endtask

  task automatic test_mid_reset;
    int busy_n = 0;
    drive(1, 0, 0, 2'b00, 4'd0, 16'h0);
    tick;
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 2'b00, 4'd0, 16'h0);
      tick;
    end
    drive(1, 0, 0, 2'b00, 4'd0, 16'h0);
    tick;
    while (!m_ready && busy_n < 40) begin
      drive(0, 1, 1, 2'b11, 4'(busy_n), 16'hFFFF);
      n_cmp++;
      if (bsy0 !== 1'b1 || rdy0 !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_busy cyc=%0d got bsy=%b rdy=%b want 1 0",
                 busy_n, bsy0, rdy0);
      end
      tick;
      busy_n++;
    end
    for (int a = 0; a < 16; a++) begin
      drive(0, 0, 0, 2'b00, 4'(a), 16'h0);
      n_cmp++;
      if (rdy0 !== 1'b1 || do0 !== 16'h0) begin
        n_err++;
        $display("FAIL midrst_read a=%0d got rdy=%b do=%h want 1 0000",
                 a, rdy0, do0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_clear;
    test_byte_lane;
    test_reg_read;
    test_wrap;
    test_random;
    test_mid_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_banked.md
Name: data_mem_banked

Overview:
- Parametrised single-port data memory for the CSE141L processor datapath.
- Successor to the 8x256 byte memory. Adds:
  - a W-bit word with per-byte write enables;
  - selectable read latency (combinational or registered);
  - a hardware clear sequencer that zeroes every entry after reset;
  - a req/ready handshake so the core stalls while memory is busy.
- Sits between the core's load/store path and the top level. It is the only data store.

Parameters:
- W, 8, data width in bits. Must be a multiple of 8.
- A, 8, address width. Depth is 2**A entries.
- RD_LAT, 0, read latency. 0 = combinational read; 1 = registered read.
- CLEAR_ON_RESET, 1, 1 = zero all entries after reset; 0 = skip the clear, contents undefined.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high.
- Req  in  1  access request, sampled on posedge.
- WriteEn  in  1  1 = write, 0 = read; qualified by Req.
- ByteEn  in  W/8  per-byte write lane enables; ignored on reads.
- DataAddress  in  A  word address.
- DataIn  in  W  write data.
- Ready  out  1  memory accepts a request this cycle.
- Busy  out  1  clear sequence in progress.
- DataOut  out  W  read data.
- DataValid  out  1  DataOut holds the result of an accepted read.

Behaviour:
- Clock and reset: clock Clk; reset Reset, synchronous, active-high.
- FSM states (in the shared package):
  - CLEAR: zero-fill sequence.
  - RUN: normal operation.
- Reset:
  - While Reset=1: state <= CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Clear counter <= 0, DataOut register <= 0, DataValid register <= 0.
  - Memory array is not written while Reset=1.
- Output values during reset:
  - Ready=0 and Busy=CLEAR_ON_RESET while Reset=1.
  - With RD_LAT=1, DataOut=0 and DataValid=0 from the first cycle after Reset.
- CLEAR state:
  - Each cycle writes all-zero to Core[counter], all lanes, then counter increments.
  - When counter = 2**A-1 and that write completes, state -> RUN.
  - Total length: exactly 2**A cycles after Reset deasserts.
  - Busy=1 and Ready=0 throughout; Req is ignored (no write, no DataValid).
- Reset mid-CLEAR: counter restarts at 0 and the full clear repeats.
- RUN state: Ready=1, Busy=0.
  - Accepted access = Req & Ready.
- Write (accepted, WriteEn=1):
  - At posedge, for each lane i with ByteEn[i]=1, Core[DataAddress][8i+7:8i] <= DataIn[8i+7:8i].
  - Other lanes keep their value.
  - ByteEn=0 leaves the entry unchanged.
  - DataValid=0 for a write.
- Read, RD_LAT=0:
  - DataOut = Core[DataAddress] combinationally, every cycle regardless of Req.
  - DataValid = Req & Ready & ~WriteEn, same cycle.
- Read, RD_LAT=1:
  - On an accepted read, DataOut register <= Core[DataAddress] and DataValid register <= 1. Data appears on the cycle after acceptance.
  - Otherwise DataValid <= 0 and DataOut holds its last value.
- Single port: one access per cycle; there is no simultaneous read and write.
- Read-after-write to the same address on the next cycle returns the new data, for both RD_LAT values.
- Addresses wrap naturally at A bits; no out-of-range condition exists.
- The clear counter is A bits wide; the terminal count is all-ones.

Decomposition:
- Package data_mem_pkg holds:
  - typedef enum logic {ST_CLEAR, ST_RUN} mem_state_t;
  - function/constant BYTES(W) = W/8.
- Sub-module data_mem_array: pure storage with a combinational read port and a lane-masked write port (we, be, addr, wdata, rdata).
- The top level owns the FSM, the clear counter, the write-port muxing (clear vs. core), and the RD_LAT output register via a generate block.

Test Plan:
- Clear sequence (W=16, A=4, CLEAR_ON_RESET=1):
  - Stimulus: Reset for 2 cycles, then release.
  - Required: Busy=1 and Ready=0 for exactly 16 cycles, then Ready=1.
  - Reads of addresses 0..15 return 0x0000.
- Byte-lane write (W=16, A=4):
  - Stimulus: write 0xABCD to addr 3 with ByteEn=2'b11; then write 0x1200 with ByteEn=2'b10; then read addr 3.
  - Required: read returns 0x12CD.
- Registered read (RD_LAT=1):
  - Stimulus: write 0x5A5A to addr 7; next cycle issue a read of addr 7.
  - Required: DataValid=1 and DataOut=0x5A5A exactly one cycle after the read is accepted.
  - DataValid=0 on the following idle cycle, with DataOut held at 0x5A5A.
- Requests during clear:
  - Stimulus: during CLEAR, assert Req/WriteEn with 0xFFFF to addr 9.
  - Required: no DataValid; after CLEAR, addr 9 reads 0x0000.
- Reset mid-clear:
  - Stimulus: assert Reset at clear cycle 10 (A=4), then release.
  - Required: Busy stays 1 for a full 16 further cycles; all entries are 0.
- Address wrap and combinational read (A=4, RD_LAT=0):
  - Stimulus: write 0x0011 to addr 15, then write 0x0022 to addr 0.
  - Required: same-cycle DataOut returns 0x0011 for addr 15 and 0x0022 for addr 0, with DataValid=1 only when Req=1.
